duft_run_sequencer: RTL and testbench

//  Hardware host that runs one DUT job through the DUFT ap_ctrl_chain wrapper, with no testbench or CPU in the loop.

---
 rtl/duft_run_sequencer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_duft_run_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/duft_run_sequencer.sv
// duft_run_sequencer
//   Hardware host that runs one DUT job through the DUFT ap_ctrl_chain
//   wrapper. A 32-bit job word is taken on the job port. The block then issues
//   this memory-mapped command sequence on the DUFT bus:
//     DUT_IN write, then INPUT/RUN/ENDR opcode phases with status polling,
//     then DUT_OUT read.
//   The DUT result is returned on the res port.
//
// Optional feature macro: DUFT_SEQ_TIMEOUT_EN
//   Defined   : each status poll phase is bounded to POLL_LIMIT reads. On
//               expiry, res_err=1 and res_data carries the last status word.
//   Undefined : polling is unbounded and res_err is tied low.
//
// Ports
//   clk, ap_rst_n                 clock (rising edge), async active-low reset
//   job_valid/job_ready/job_data  job request handshake and DUT input word
//   res_valid/res_ready/res_data  result handshake and DUT output word
//   res_err                       job aborted by poll timeout
//   busy                          job in progress (accept through result handshake)
//   m_addr/m_wr_data/m_rd_wr      DUFT address, write data, 1=read 0=write
//   m_ap_start/m_ap_continue      DUFT ap_ctrl_chain controls
//   m_ap_return/m_ap_idle/m_ap_done/m_ap_ready  DUFT ap_ctrl_chain status
module duft_run_sequencer #(
    parameter logic [31:0] OPCODE_BASE  = 32'h0000_0000,
    parameter logic [31:0] STATE_BASE   = 32'h0000_0001,
    parameter logic [31:0] DUT_IN_BASE  = 32'h0000_0010,
    parameter logic [31:0] DUT_OUT_BASE = 32'h0000_0018,
    parameter logic [31:0] INVALID_ADDR = 32'hFFFF_FFFF,
    parameter int unsigned POLL_GAP     = 1,
    parameter int unsigned POLL_LIMIT   = 200
) (
    input  logic        clk,
    input  logic        ap_rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic [31:0] m_addr,
    output logic [31:0] m_wr_data,
    output logic        m_rd_wr,
    output logic        m_ap_start,
    output logic        m_ap_continue,
    input  logic [31:0] m_ap_return,
    input  logic        m_ap_idle,
    input  logic        m_ap_done,
    input  logic        m_ap_ready
);
    typedef enum logic [1:0] {B_IDLE, B_WAIT_IDLE, B_WAIT_DONE} bus_state_t;
    typedef enum logic [2:0] {T_IDLE, T_WR_IN, T_OP, T_OP_CLR, T_POLL, T_RD_OUT, T_RESP} top_state_t;

    localparam logic [1:0] PH_INPUT = 2'd1;
    localparam logic [1:0] PH_ENDR  = 2'd3;
    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

    // Bus sub-FSM state
    bus_state_t  bus_state_q, bus_state_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wr_data_q, m_wr_data_d;
    logic        m_rd_wr_q, m_rd_wr_d;
    logic        m_ap_start_q, m_ap_start_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        bus_done_q, bus_done_d;

    // Top FSM state
    top_state_t  top_state_q, top_state_d;
    logic [1:0]  ph_q, ph_d;
    logic [31:0] job_q, job_d;
    logic [31:0] res_data_q, res_data_d;
    logic [7:0]  gap_q, gap_d;
`ifdef DUFT_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        res_err_q, res_err_d;
`endif

    // Request from the top FSM to the bus sub-FSM
    logic        bus_req;
    logic        req_state;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic        req_rd;
    logic [3:0]  exp_status;

    always_comb begin
        req_state   = 1'b1;
        req_addr    = INVALID_ADDR;
        req_wr_data = 32'd0;
        req_rd      = 1'b1;
        case (top_state_q)
            T_WR_IN:  begin req_addr = DUT_IN_BASE; req_wr_data = job_q;          req_rd = 1'b0; end
            T_OP:     begin req_addr = OPCODE_BASE; req_wr_data = {30'd0, ph_q};  req_rd = 1'b0; end
            T_OP_CLR: begin req_addr = OPCODE_BASE; req_wr_data = 32'd0;          req_rd = 1'b0; end
            T_POLL:   req_addr = STATE_BASE;
            T_RD_OUT: req_addr = DUT_OUT_BASE;
            default:  req_state = 1'b0;
        endcase
        // bus_done_q blocks re-issue in the cycle the top FSM consumes a completion.
        bus_req = req_state && (bus_state_q == B_IDLE) && !bus_done_q && (gap_q == 8'd0);
    end

    always_comb begin
        case (ph_q)
            PH_INPUT: exp_status = 4'h3;
            2'd2:     exp_status = 4'h5;
            default:  exp_status = 4'h0;
        endcase
    end

    // Bus sub-FSM: one ap_ctrl_chain transaction at a time
    always_comb begin
        bus_state_d   = bus_state_q;
        m_addr_d      = m_addr_q;
        m_wr_data_d   = m_wr_data_q;
        m_rd_wr_d     = m_rd_wr_q;
        m_ap_start_d  = m_ap_start_q;
        rd_data_d     = rd_data_q;
        bus_done_d    = 1'b0;
        m_ap_continue = 1'b0;
        case (bus_state_q)
            B_IDLE: begin
                if (bus_req) begin
                    m_addr_d    = req_addr;
                    m_wr_data_d = req_wr_data;
                    m_rd_wr_d   = req_rd;
                    bus_state_d = B_WAIT_IDLE;
                end
            end
            B_WAIT_IDLE: begin
                if (m_ap_idle) begin
                    m_ap_start_d = 1'b1;
                    bus_state_d  = B_WAIT_DONE;
                end
            end
            B_WAIT_DONE: begin
                if (m_ap_done) begin
                    m_ap_continue = 1'b1;
                    if (m_rd_wr_q) rd_data_d = m_ap_return;
                    m_ap_start_d = 1'b0;
                    m_addr_d     = INVALID_ADDR;
                    m_rd_wr_d    = 1'b1;
                    bus_done_d   = 1'b1;
                    bus_state_d  = B_IDLE;
                end
            end
            default: bus_state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bus_state_q  <= B_IDLE;
            m_addr_q     <= INVALID_ADDR;
            m_wr_data_q  <= 32'd0;
            m_rd_wr_q    <= 1'b1;
            m_ap_start_q <= 1'b0;
            rd_data_q    <= 32'd0;
            bus_done_q   <= 1'b0;
        end else begin
            bus_state_q  <= bus_state_d;
            m_addr_q     <= m_addr_d;
            m_wr_data_q  <= m_wr_data_d;
            m_rd_wr_q    <= m_rd_wr_d;
            m_ap_start_q <= m_ap_start_d;
            rd_data_q    <= rd_data_d;
            bus_done_q   <= bus_done_d;
        end
    end

    // Top FSM: sequences the command phases of one job
    always_comb begin
        top_state_d = top_state_q;
        ph_d        = ph_q;
        job_d       = job_q;
        res_data_d  = res_data_q;
        gap_d       = gap_q;
`ifdef DUFT_SEQ_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        res_err_d   = res_err_q;
`endif
        case (top_state_q)
            T_IDLE: begin
                if (job_valid) begin
                    job_d       = job_data;
                    ph_d        = PH_INPUT;
`ifdef DUFT_SEQ_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                    top_state_d = T_WR_IN;
                end
            end
            T_WR_IN:  if (bus_done_q) top_state_d = T_OP;
            T_OP:     if (bus_done_q) top_state_d = T_OP_CLR;
            T_OP_CLR: begin
                if (bus_done_q) begin
`ifdef DUFT_SEQ_TIMEOUT_EN
                    poll_cnt_d  = 16'd0;
`endif
                    top_state_d = T_POLL;
                end
            end
            T_POLL: begin
                if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
                if (bus_done_q) begin
                    if (rd_data_q[3:0] == exp_status) begin
                        if (ph_q == PH_ENDR) begin
                            top_state_d = T_RD_OUT;
                        end else begin
                            ph_d        = ph_q + 2'd1;
                            top_state_d = T_OP;
                        end
                    end else begin
`ifdef DUFT_SEQ_TIMEOUT_EN
                        // poll_cnt_q counts mismatching reads already seen this phase.
                        if ((32'(poll_cnt_q) + 32'd1) >= POLL_LIMIT) begin
                            res_err_d   = 1'b1;
                            res_data_d  = rd_data_q;
                            top_state_d = T_RESP;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 16'd1;
                            gap_d      = GAP_LOAD;
                        end
`else
                        gap_d = GAP_LOAD;
`endif
                    end
                end
            end
            T_RD_OUT: begin
                if (bus_done_q) begin
                    res_data_d  = rd_data_q;
                    top_state_d = T_RESP;
                end
            end
            T_RESP:   if (res_ready) top_state_d = T_IDLE;
            default:  top_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            top_state_q <= T_IDLE;
            ph_q        <= 2'd0;
            job_q       <= 32'd0;
            res_data_q  <= 32'd0;
            gap_q       <= 8'd0;
`ifdef DUFT_SEQ_TIMEOUT_EN
            poll_cnt_q  <= 16'd0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            top_state_q <= top_state_d;
            ph_q        <= ph_d;
            job_q       <= job_d;
            res_data_q  <= res_data_d;
            gap_q       <= gap_d;
`ifdef DUFT_SEQ_TIMEOUT_EN
            poll_cnt_q  <= poll_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign job_ready  = (top_state_q == T_IDLE);
    assign res_valid  = (top_state_q == T_RESP);
    assign busy       = (top_state_q != T_IDLE);
    assign res_data   = res_data_q;
    assign m_addr     = m_addr_q;
    assign m_wr_data  = m_wr_data_q;
    assign m_rd_wr    = m_rd_wr_q;
    assign m_ap_start = m_ap_start_q;
`ifdef DUFT_SEQ_TIMEOUT_EN
    assign res_err    = res_err_q;
`else
    assign res_err    = 1'b0;
`endif

    // m_ap_ready is reserved; POLL_LIMIT only matters with the timeout enabled.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, m_ap_ready, POLL_LIMIT[0]};
endmodule

// File: tb/tb_duft_run_sequencer.sv
module tb_duft_run_sequencer;
    localparam logic [31:0] INVALID = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_data = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic [31:0] m_addr, m_wr_data, m_ap_return;
    logic        m_rd_wr, m_ap_start, m_ap_continue, m_ap_idle, m_ap_done, m_ap_ready;

    always #5 clk = ~clk;

    duft_run_sequencer #(.POLL_LIMIT(4)) dut (
        .clk(clk), .ap_rst_n(ap_rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy),
        .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_wr(m_rd_wr),
        .m_ap_start(m_ap_start), .m_ap_continue(m_ap_continue),
        .m_ap_return(m_ap_return), .m_ap_idle(m_ap_idle),
        .m_ap_done(m_ap_done), .m_ap_ready(m_ap_ready)
    );

    // DUFT ap_ctrl_chain stub: DUT adds 8; status reaches the new state on
    // the third read after an opcode write.
    logic        st_busy = 0, st_done = 0, force_busy = 0, stuck = 0;
    logic [1:0]  st_cnt = 0, st_lag = 0;
    logic [3:0]  st_cur = 0, st_pend = 0;
    logic [31:0] st_in = 0, st_out = 0, st_ret = 0;

    assign m_ap_idle   = !st_busy && !force_busy;
    assign m_ap_done   = st_done;
    assign m_ap_ready  = st_done;
    assign m_ap_return = st_ret;

    always @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            st_busy <= 0; st_done <= 0; st_cnt <= 0; st_lag <= 0;
            st_cur <= 0; st_pend <= 0; st_in <= 0; st_out <= 0; st_ret <= 0;
        end else if (st_done) begin
            if (m_ap_continue) begin st_done <= 0; st_busy <= 0; end
        end else if (st_busy) begin
            if (st_cnt == 0) st_done <= 1; else st_cnt <= st_cnt - 1;
        end else if (m_ap_start && !force_busy) begin
            st_busy <= 1; st_cnt <= 1;
            if (!m_rd_wr) begin
                if (m_addr == 32'h10) st_in <= m_wr_data;
                else if (m_addr == 32'h0 && m_wr_data != 32'd0) begin
                    st_lag <= 2;
                    case (m_wr_data)
                        32'd1: st_pend <= 4'h3;
                        32'd2: begin st_pend <= 4'h5; st_out <= st_in + 32'd8; end
                        default: st_pend <= 4'h0;
                    endcase
                end
            end else if (m_addr == 32'h1) begin
                if (stuck) st_ret <= 32'h7;
                else if (st_lag != 0) begin st_lag <= st_lag - 1; st_ret <= {28'd0, st_cur}; end
                else begin st_cur <= st_pend; st_ret <= {28'd0, st_pend}; end
            end else if (m_addr == 32'h18) st_ret <= st_out;
        end
    end

    // Scoreboard and checking
    typedef struct { logic [31:0] data; logic err; int ntx; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int tx_count = 0, tx_base = 0, acc_cnt = 0, hs_cnt = 0, rv_cycles = 0, cont_cnt = 0;
    bit in_txn = 0;
    logic [31:0] last_op = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: bus protocol, accept ordering, result comparison.
    always @(negedge clk) begin
        if (!ap_rst_n) begin
            in_txn = 0; cont_cnt = 0; hs_cnt = acc_cnt;
        end else begin
            if (m_ap_start) begin
                if (!in_txn) begin
                    in_txn = 1; cont_cnt = 0; tx_count++;
                    if (m_addr == 32'h0 && !m_rd_wr && m_wr_data != 32'd0) last_op = m_wr_data;
                end
                if (m_ap_continue) cont_cnt++;
            end else if (in_txn) begin
                chk("continue_per_start", 32'(cont_cnt), 32'd1);
                in_txn = 0; cont_cnt = 0;
            end
            if (res_valid) rv_cycles++;
            if (job_valid && job_ready) begin
                chk("accept_after_handshake", 32'(acc_cnt), 32'(hs_cnt));
                acc_cnt++; tx_base = tx_count;
            end
            if (res_valid && res_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got 0x%08h expected no result", res_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("res_data", res_data, mon_e.data);
                    chk("res_err", {31'd0, res_err}, {31'd0, mon_e.err});
                    chk("bus_tx_per_job", 32'(tx_count - tx_base), 32'(mon_e.ntx));
                end
                $display("RESULT data=0x%08h err=%0b", res_data, res_err);
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic e, input int n);
        exp_t x;
        x.data = d; x.err = e; x.ntx = n;
        sb_q.push_back(x);
    endtask

    task automatic issue(input logic [31:0] d, input bit keep);
        bit got = 0;
        @(posedge clk); #1;
        job_valid = 1; job_data = d;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (job_ready) begin @(posedge clk); #1; got = 1; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL job_accept_timeout: got no accept expected accept of 0x%08h", d);
        end
        if (!keep) job_valid = 0;
        $display("JOB 0x%08h issued", d);
    endtask

    task automatic wait_drain();
        bit got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL result_timeout: got %0d pending expected 0 pending", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    int v_valid, v_data, v_busy, v_bus, t0, viol;
    logic [31:0] d0;
    bit got;

    initial begin
        #2 ap_rst_n = 0;
        #1;
        chk("rst_job_ready", {31'd0, job_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ap_start", {31'd0, m_ap_start}, 32'd0);
        chk("rst_ap_continue", {31'd0, m_ap_continue}, 32'd0);
        chk("rst_res_err", {31'd0, res_err}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_wr_data", m_wr_data, 32'd0);
        chk("rst_rd_wr", {31'd0, m_rd_wr}, 32'd1);
        chk("rst_addr", m_addr, INVALID);
        repeat (2) @(posedge clk);
        #2 ap_rst_n = 1;

        // 1: single job
        push(32'h0000_721E, 1'b0, 17);
        issue(32'h0000_7216, 1'b0);
        wait_drain();
        chk("t1_res_valid_cycles", 32'(rv_cycles), 32'd1);

        // 2: back-to-back with job_valid held
        push(32'h0000_072A, 1'b0, 17);
        push(32'h0000_721E, 1'b0, 17);
        issue(32'h0000_0722, 1'b1);
        issue(32'h0000_7216, 1'b0);
        wait_drain();

        // 3: result backpressure
        res_ready = 0;
        push(32'h0000_0108, 1'b0, 17);
        issue(32'h0000_0100, 1'b0);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin @(negedge clk); if (res_valid) got = 1; end
        chk("t3_res_valid_seen", {31'd0, got}, 32'd1);
        d0 = res_data; t0 = tx_count; v_valid = 0; v_data = 0; v_busy = 0; v_bus = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid) v_valid++;
            if (res_data !== d0 || res_err !== 1'b0) v_data++;
            if (!busy) v_busy++;
            if (m_ap_start || tx_count != t0) v_bus++;
        end
        chk("t3_valid_drops", 32'(v_valid), 32'd0);
        chk("t3_data_changes", 32'(v_data), 32'd0);
        chk("t3_busy_drops", 32'(v_busy), 32'd0);
        chk("t3_bus_traffic", 32'(v_bus), 32'd0);
        @(posedge clk); #1 res_ready = 1;
        wait_drain();

        // 4: reset during RUN phase status polling
        issue(32'h0000_0005, 1'b0);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (m_ap_start && m_addr == 32'h1 && last_op == 32'd2) got = 1;
        end
        chk("t4_run_poll_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #2 ap_rst_n = 0;
        #1;
        chk("t4_ap_start", {31'd0, m_ap_start}, 32'd0);
        chk("t4_addr", m_addr, INVALID);
        chk("t4_job_ready", {31'd0, job_ready}, 32'd1);
        @(posedge clk); #2 ap_rst_n = 1;
        push(32'h0000_0009, 1'b0, 17);
        issue(32'h0000_0001, 1'b0);
        wait_drain();

        // 5: DUFT not idle for 15 cycles
        force_busy = 1;
        push(32'h0000_0028, 1'b0, 17);
        issue(32'h0000_0020, 1'b0);
        viol = 0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (m_ap_start) viol++; end
        chk("t5_start_while_busy", 32'(viol), 32'd0);
        chk("t5_addr_held", m_addr, 32'h10);
        @(posedge clk); #1 force_busy = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (m_ap_start) got = 1; end
        chk("t5_start_after_idle", {31'd0, got}, 32'd1);
        wait_drain();

`ifdef DUFT_SEQ_TIMEOUT_EN
        // 6: stuck status, timeout after 4 reads
        stuck = 1;
        push(32'h0000_0007, 1'b1, 7);
        issue(32'h0000_00AB, 1'b0);
        wait_drain();
        stuck = 0;
        push(32'h0000_0038, 1'b0, 17);
        issue(32'h0000_0030, 1'b0);
        wait_drain();
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
